// File: rtl/spi_stream_ctrl.sv
// spi_stream_ctrl
//   Upstream sequencer for spi_front. Takes TX words from an AXI-Stream
//   slave, drives spi_begin/spi_wide/data_mosi, waits for spi_busy to rise
//   and fall, then returns the captured data_miso word on an AXI-Stream
//   master. Owns chip select: held low across a multi-word frame and
//   released CS_HOLD cycles after the tlast word finishes.
//
// Parameters
//   CS_SETUP : cycles from spi_cs_n falling to the first spi_begin (>= 1)
//   CS_HOLD  : cycles from last transfer done to spi_cs_n rising   (>= 1)
//
// Ports
//   spi_clk_in        clock (posedge here; spi_front uses the negedge)
//   rst               synchronous active-high reset
//   s_axis_*          TX stream; tuser=1 selects a 32-bit transfer, tlast ends frame
//   m_axis_*          RX stream; 8-bit results are zero-extended
//   spi_cs_n          chip select, active low
//   spi_begin         start request to spi_front
//   spi_wide          1 = 32-bit transfer, 0 = 8-bit
//   data_mosi         word to shift out
//   data_miso         word shifted in by spi_front
//   spi_busy          spi_front transfer in progress

module spi_stream_ctrl #(
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic        spi_clk_in,
    input  logic        rst,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        spi_cs_n,
    output logic        spi_begin,
    output logic        spi_wide,
    output logic [31:0] data_mosi,
    input  logic [31:0] data_miso,
    input  logic        spi_busy
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SETUP    = 3'd1;
    localparam logic [2:0] SEL_WAIT = 3'd2;
    localparam logic [2:0] START    = 3'd3;
    localparam logic [2:0] XFER     = 3'd4;
    localparam logic [2:0] HOLD     = 3'd5;

    logic [2:0] state;
    logic [7:0] count;
    logic       last_q;
    logic       rx_free;
    logic       accept;

    // A new word is only taken when the single RX slot is guaranteed to be
    // empty by the time its result comes back.
    assign rx_free       = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = !rst && rx_free && (state == IDLE || state == SEL_WAIT);
    assign accept        = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge spi_clk_in) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            last_q        <= 1'b0;
            spi_cs_n      <= 1'b1;
            spi_begin     <= 1'b0;
            spi_wide      <= 1'b0;
            data_mosi     <= '0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else begin
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            // data_mosi/spi_wide double as the TX word latch, so they stay
            // stable from acceptance until the transfer completes.
            if (accept) begin
                data_mosi <= s_axis_tdata;
                spi_wide  <= s_axis_tuser;
                last_q    <= s_axis_tlast;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        spi_cs_n <= 1'b0;
                        count    <= 8'(CS_SETUP - 1);
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (count == '0) begin
                        spi_begin <= 1'b1;
                        state     <= START;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                SEL_WAIT: begin
                    if (accept) begin
                        spi_begin <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    // Drop the request as soon as spi_front acknowledges so it
                    // cannot be seen again when the transfer ends.
                    if (spi_busy) begin
                        spi_begin <= 1'b0;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (!spi_busy) begin
                        m_axis_tdata  <= spi_wide ? data_miso : {24'b0, data_miso[7:0]};
                        m_axis_tuser  <= spi_wide;
                        m_axis_tlast  <= last_q;
                        m_axis_tvalid <= 1'b1;
                        if (last_q) begin
                            count <= 8'(CS_HOLD - 1);
                            state <= HOLD;
                        end else begin
                            state <= SEL_WAIT;
                        end
                    end
                end
                HOLD: begin
                    if (count == '0) begin
                        spi_cs_n <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                default: begin
                    spi_cs_n  <= 1'b1;
                    spi_begin <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_stream_ctrl.sv
// tb_spi_stream_ctrl
//   Directed bench for spi_stream_ctrl. A small behavioural spi_front model
//   answers spi_begin on the negedge, shifts the MOSI word out MSB first,
//   counts SCLK pulses and returns a queued response on data_miso.

module tb_spi_stream_ctrl;

    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_tdata = '0;
    logic        s_tuser = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tuser;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        cs_n;
    logic        spi_begin;
    logic        spi_wide;
    logic [31:0] data_mosi;
    logic [31:0] data_miso = '0;
    logic        spi_busy = 1'b0;

    always #5 clk = ~clk;

    spi_stream_ctrl #(.CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
        .spi_clk_in    (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tuser  (s_tuser),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tuser  (m_tuser),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .spi_cs_n      (cs_n),
        .spi_begin     (spi_begin),
        .spi_wide      (spi_wide),
        .data_mosi     (data_mosi),
        .data_miso     (data_miso),
        .spi_busy      (spi_busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- spi_front model ----------------
    logic [31:0] mw;
    logic        wide_m;
    int          nbits = 0;
    int          bits_done = 0;
    logic [31:0] shifted;
    int          starts = 0;
    logic [31:0] resp_q[$];
    logic [31:0] done_mosi[$];
    int          done_bits[$];

    initial forever begin
        @(negedge clk);
        if (rst) begin
            spi_busy  = 1'b0;
            bits_done = 0;
        end else if (!spi_busy) begin
            if (spi_begin) begin
                spi_busy  = 1'b1;
                mw        = data_mosi;
                wide_m    = spi_wide;
                nbits     = wide_m ? 32 : 8;
                bits_done = 0;
                shifted   = '0;
                starts++;
            end
        end else begin
            shifted = {shifted[30:0], wide_m ? mw[31 - bits_done] : mw[7 - bits_done]};
            bits_done++;
            if (bits_done == nbits) begin
                spi_busy  = 1'b0;
                data_miso = (resp_q.size() > 0) ? resp_q.pop_front() : 32'h0;
                done_mosi.push_back(shifted);
                done_bits.push_back(bits_done);
            end
        end
    end

    // ---------------- monitor (samples 3 time units after posedge) ----------------
    int   cyc = 0;
    int   cs_fall_cyc = 0, cs_rise_cyc = 0, begin_rise_cyc = 0, begin_fall_cyc = 0;
    int   busy_fall_cyc = 0;
    int   cs_rise_cnt = 0, begin_cnt = 0, accepts = 0;
    int   gaps[$];
    logic [31:0] rx_data[$];
    logic        rx_user[$];
    logic        rx_last[$];
    logic prev_cs = 1'b1, prev_begin = 1'b0, prev_busy = 1'b0;

    initial forever begin
        @(posedge clk);
        #3;
        cyc++;
        if (!rst) begin
            if (prev_cs && !cs_n) cs_fall_cyc = cyc;
            if (!prev_cs && cs_n) begin
                cs_rise_cyc = cyc;
                cs_rise_cnt++;
            end
            if (!prev_begin && spi_begin) begin
                begin_rise_cyc = cyc;
                begin_cnt++;
                gaps.push_back(cyc - busy_fall_cyc);
            end
            if (prev_begin && !spi_begin) begin_fall_cyc = cyc;
            if (prev_busy && !spi_busy) busy_fall_cyc = cyc;
            if (m_tvalid && m_tready) begin
                rx_data.push_back(m_tdata);
                rx_user.push_back(m_tuser);
                rx_last.push_back(m_tlast);
            end
            if (s_tvalid && s_tready) accepts++;
        end
        prev_cs    = cs_n;
        prev_begin = spi_begin;
        prev_busy  = spi_busy;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [31:0] d, input logic u, input logic l);
        int   budget;
        logic ok;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        #1;
        budget = 300;
        ok     = 1'b0;
        while (!ok && budget > 0) begin
            if (s_tready) ok = 1'b1;
            else begin
                tick();
                budget--;
            end
        end
        check("tx_accept", ok, 1'b1);
        if (ok) tick();
        s_tvalid = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int budget = 400;
        while (rx_data.size() < n && budget > 0) begin
            tick();
            budget--;
        end
        check("rx_count", rx_data.size(), n);
    endtask

    task automatic wait_cs_high();
        int budget = 100;
        while (!cs_n && budget > 0) begin
            tick();
            budget--;
        end
        check("cs_release", cs_n, 1'b1);
        tick();
    endtask

    function automatic int gap_at(input int i);
        return (i < gaps.size()) ? gaps[i] : -1;
    endfunction

    task automatic clear_logs();
        rx_data.delete();
        rx_user.delete();
        rx_last.delete();
        done_mosi.delete();
        done_bits.delete();
        gaps.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cs0;
        int   beg0;
        int   acc0;

        // ---------- reset state ----------
        repeat (3) tick();
        check("rst_cs_n", cs_n, 1'b1);
        check("rst_begin", spi_begin, 1'b0);
        check("rst_s_tready", s_tready, 1'b0);
        check("rst_m_tvalid", m_tvalid, 1'b0);
        check("rst_mosi", data_mosi, 32'h0);
        rst = 1'b0;
        tick();
        check("idle_s_tready", s_tready, 1'b1);

        // ---------- single 8-bit word ----------
        clear_logs();
        resp_q.push_back(32'hFFFF_FF3C);
        push_tx(32'h0000_00A5, 1'b0, 1'b1);
        wait_rx(1);
        wait_cs_high();
        check("b8_setup_cycles", begin_rise_cyc - cs_fall_cyc, CS_SETUP);
        check("b8_begin_width", begin_fall_cyc - begin_rise_cyc, 1);
        check("b8_sclk_pulses", done_bits.size() > 0 ? done_bits[0] : -1, 8);
        check("b8_mosi_bits", done_mosi.size() > 0 ? done_mosi[0] : 32'hX, 32'h0000_00A5);
        check("b8_rx_data", rx_data[0], 32'h0000_003C);
        check("b8_rx_user", rx_user[0], 1'b0);
        check("b8_rx_last", rx_last[0], 1'b1);
        check("b8_hold_cycles", cs_rise_cyc - busy_fall_cyc, CS_HOLD);

        // ---------- 32-bit word ----------
        clear_logs();
        resp_q.push_back(32'h1234_5678);
        push_tx(32'hDEAD_BEEF, 1'b1, 1'b1);
        wait_rx(1);
        wait_cs_high();
        check("w32_sclk_pulses", done_bits.size() > 0 ? done_bits[0] : -1, 32);
        check("w32_mosi_bits", done_mosi.size() > 0 ? done_mosi[0] : 32'hX, 32'hDEAD_BEEF);
        check("w32_rx_data", rx_data[0], 32'h1234_5678);
        check("w32_rx_user", rx_user[0], 1'b1);
        check("w32_begin_width", begin_fall_cyc - begin_rise_cyc, 1);

        // ---------- three-word frame ----------
        clear_logs();
        cs0 = cs_rise_cnt;
        resp_q.push_back(32'h5500_00AA);
        resp_q.push_back(32'h5500_00BB);
        resp_q.push_back(32'h5500_00CC);
        push_tx(32'h0000_0001, 1'b0, 1'b0);
        push_tx(32'h0000_0002, 1'b0, 1'b0);
        push_tx(32'h0000_0003, 1'b0, 1'b1);
        wait_rx(3);
        wait_cs_high();
        check("frm_cs_rises", cs_rise_cnt - cs0, 1);
        check("frm_gap_w2", gap_at(1), 1);
        check("frm_gap_w3", gap_at(2), 1);
        check("frm_rx0", rx_data[0], 32'h0000_00AA);
        check("frm_rx1", rx_data[1], 32'h0000_00BB);
        check("frm_rx2", rx_data[2], 32'h0000_00CC);
        check("frm_last0", rx_last[0], 1'b0);
        check("frm_last1", rx_last[1], 1'b0);
        check("frm_last2", rx_last[2], 1'b1);
        check("frm_mosi2", done_mosi.size() > 2 ? done_mosi[2] : 32'hX, 32'h0000_0003);

        // ---------- backpressure ----------
        clear_logs();
        m_tready = 1'b0;
        resp_q.push_back(32'h0000_005A);
        resp_q.push_back(32'h0000_006B);
        resp_q.push_back(32'h0000_007C);
        push_tx(32'h0000_0011, 1'b0, 1'b0);
        begin
            int budget = 100;
            while (!m_tvalid && budget > 0) begin
                tick();
                budget--;
            end
        end
        check("bp_first_valid", m_tvalid, 1'b1);
        beg0 = begin_cnt;
        acc0 = accepts;
        fork
            begin
                push_tx(32'h0000_0022, 1'b0, 1'b0);
                push_tx(32'h0000_0033, 1'b0, 1'b1);
            end
        join_none
        repeat (30) tick();
        check("bp_no_begin", begin_cnt - beg0, 0);
        check("bp_no_accept", accepts - acc0, 0);
        check("bp_s_tready", s_tready, 1'b0);
        check("bp_rx_stable", m_tdata, 32'h0000_005A);
        check("bp_cs_held", cs_n, 1'b0);
        m_tready = 1'b1;
        wait fork;
        wait_rx(3);
        wait_cs_high();
        check("bp_rx0", rx_data[0], 32'h0000_005A);
        check("bp_rx1", rx_data[1], 32'h0000_006B);
        check("bp_rx2", rx_data[2], 32'h0000_007C);

        // ---------- reset mid-XFER ----------
        clear_logs();
        resp_q.delete();
        resp_q.push_back(32'h0BAD_BEEF);
        push_tx(32'hCAFE_F00D, 1'b1, 1'b1);
        begin
            int budget = 100;
            while (!(spi_busy && bits_done >= 12) && budget > 0) begin
                tick();
                budget--;
            end
        end
        check("rst_reached_bit12", bits_done, 12);
        rst = 1'b1;
        tick();
        check("mid_rst_cs_n", cs_n, 1'b1);
        check("mid_rst_begin", spi_begin, 1'b0);
        check("mid_rst_m_tvalid", m_tvalid, 1'b0);
        rst = 1'b0;
        repeat (2) tick();
        check("mid_rst_no_rx", rx_data.size(), 0);
        resp_q.delete();
        resp_q.push_back(32'h0000_0042);
        push_tx(32'h0000_0081, 1'b0, 1'b1);
        wait_rx(1);
        wait_cs_high();
        check("post_rst_rx", rx_data[0], 32'h0000_0042);
        check("post_rst_mosi", done_mosi.size() > 0 ? done_mosi[0] : 32'hX, 32'h0000_0081);
        check("post_rst_pulses", done_bits.size() > 0 ? done_bits[0] : -1, 8);

        // ---------- one spi_front transfer per accepted word ----------
        repeat (5) tick();
        check("starts_vs_accepts", starts, accepts);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_stream_ctrl.md
Name: spi_stream_ctrl

Overview:
- Upstream sequencer for spi_front, in the same spi_clk_in domain.
- Accepts TX words on an AXI-Stream slave and drives spi_begin/spi_wide/data_mosi.
- Tracks spi_busy, captures data_miso, and returns each RX word on an AXI-Stream master.
- Owns chip select: asserted across a multi-word frame, released after tlast.

Parameters:
CS_SETUP, 2, spi_clk_in cycles from spi_cs_n falling to first spi_begin (min 1)
CS_HOLD, 2, spi_clk_in cycles from last transfer done to spi_cs_n rising (min 1)

Ports:
spi_clk_in  in  1  clock; posedge logic; shared with spi_front (which works on negedge)
rst  in  1  synchronous, active-high reset
s_axis_tdata  in  32  TX word; 8-bit mode sends bits [7:0] MSB first
s_axis_tuser  in  1  1 = 32-bit transfer (spi_wide), 0 = 8-bit
s_axis_tlast  in  1  last word of frame; release CS afterwards
s_axis_tvalid  in  1  TX valid
s_axis_tready  out  1  TX ready
m_axis_tdata  out  32  RX word; 8-bit mode zero-extended to bits [7:0]
m_axis_tuser  out  1  copy of the TX word's tuser
m_axis_tlast  out  1  copy of the TX word's tlast
m_axis_tvalid  out  1  RX valid
m_axis_tready  in  1  RX ready
spi_cs_n  out  1  chip select, active low
spi_begin  out  1  to spi_front
spi_wide  out  1  to spi_front
data_mosi  out  32  to spi_front
data_miso  in  32  from spi_front
spi_busy  in  1  from spi_front

Behaviour:
- Reset values: state IDLE; spi_cs_n=1; spi_begin=0; spi_wide=0; data_mosi=0; s_axis_tready=0; m_axis_tvalid=0; m_axis_tdata/tuser/tlast=0; counters=0.
- Reset mid-operation aborts immediately, with no RX word emitted. spi_front's own reset is tied in at system level.
- s_axis_tready=1 only in IDLE or SEL_WAIT, and only when the RX slot is empty or drains this cycle (m_axis_tvalid=0 or m_axis_tready=1).
- On accept: latch tdata, tuser and tlast.
- States:
  - IDLE (cs_n=1): on accept -> SETUP, cs_n<=0, counter<=CS_SETUP-1.
  - SETUP: count down; at 0 -> START.
  - SEL_WAIT (cs_n=0, between words of a frame): on accept -> START directly, no setup delay.
  - START: spi_begin=1, spi_wide=latched tuser, data_mosi=latched tdata. Hold until spi_busy=1 is seen at a posedge, then spi_begin<=0 -> XFER. spi_begin must be 0 before spi_front finishes (8+ negedges later).
  - XFER: wait for spi_busy=0. Then m_axis_tdata <= tuser ? data_miso : {24'b0, data_miso[7:0]}, copy tuser/tlast, m_axis_tvalid<=1. Next: tlast -> HOLD (counter<=CS_HOLD-1); otherwise -> SEL_WAIT.
  - HOLD: count down; at 0 -> cs_n<=1, IDLE.
- data_mosi and spi_wide are held stable from START until XFER exits.
- RX slot is a single register: m_axis_tvalid clears on tvalid&tready. It is never overwritten while valid, which the tready gating guarantees.
- Latency: tvalid accept to spi_begin = CS_SETUP+1 cycles from IDLE, 1 cycle from SEL_WAIT.
- Busy edge to m_axis_tvalid = 1 cycle.
- Single-word frame: s_axis_tlast=1 on the one word.
- Word arriving while RX output is stalled: waits in IDLE/SEL_WAIT with CS held; no SPI activity.

Test Plan:
- Single 8-bit word: tdata=0x000000A5, tuser=0, tlast=1, slave echoes 0x3C -> spi_cs_n low CS_SETUP cycles before spi_begin; exactly 8 SCLK pulses; MOSI 1010_0101; RX word 0x0000003C, tlast=1; cs_n high CS_HOLD cycles after busy falls.
- 32-bit word: tdata=0xDEADBEEF, tuser=1, slave returns 0x12345678 -> 32 SCLK pulses, RX 0x12345678, m_axis_tuser=1.
- Three-word frame: 8-bit words 0x01, 0x02, 0x03 with tlast on the third -> cs_n stays low throughout; no setup delay between words; three RX words, tlast only on the third.
- Backpressure: m_axis_tready=0 after the first RX word, two more TX words queued -> s_axis_tready=0, no spi_begin, first RX word stable. Raising tready resumes and RX order is preserved.
- Reset mid-XFER of a 32-bit word (rst at bit 12) -> next posedge: cs_n=1, spi_begin=0, m_axis_tvalid=0. A following clean single word completes correctly.
- spi_begin timing: check spi_begin drops within 1 posedge of spi_busy rising, and that spi_front starts exactly one transfer per accepted word.
